cpu_sequential_rv64: RTL and testbench

//  Single-cycle (one instruction per clk) RV64 integer CPU running a small RV64I subset:
//  add, sub, and, or, addi, ld, sd, beq.

---
 rtl/cpu_sequential_rv64.sv | 241 ++++++++++++++++++++++++
 tb/tb_cpu_sequential_rv64.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequential_rv64.sv
// cpu_sequential_rv64: single-cycle RV64I subset core (add, sub, and, or, addi, ld, sd, beq).
// One instruction retires per rising clk edge; instruction ROM, register file and data RAM
// are sub-instances so their storage can be inspected and preloaded hierarchically.

// Instruction ROM: combinational read, contents supplied by hierarchical preload.
module cpu_imem #(
  parameter int IMEM_WORDS = 256,
  parameter int AW         = 8
) (
  input  logic [AW-1:0] i_addr,
  output logic [31:0]   o_data
);
  logic [31:0] memory [0:IMEM_WORDS-1] = '{default: 32'h0};

  assign o_data = memory[i_addr];
endmodule

// Data RAM: 64-bit words, combinational read, write on rising edge; never reset.
module cpu_dmem #(
  parameter int DMEM_WORDS = 256,
  parameter int AW         = 8
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [63:0]   i_wd,
  output logic [63:0]   o_rd
);
  logic [63:0] memory [0:DMEM_WORDS-1] = '{default: 64'h0};

  // store commits on the same edge as the register write and PC update
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      memory[i_addr] <= i_wd;
    end
  end

  assign o_rd = memory[i_addr];
endmodule

// Register file: 32 x 64-bit, two combinational read ports, one write port; x0 hardwired to zero.
module cpu_reg_file (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [4:0]  i_rd,
  input  logic [63:0] i_wd,
  output logic [63:0] o_rd1,
  output logic [63:0] o_rd2
);
  logic [31:0][63:0] registers;

  // async clear of the whole file; writes to x0 are dropped so it stays zero
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      registers <= '0;
    end else if (i_we && (i_rd != 5'd0)) begin
      registers[i_rd] <= i_wd;
    end
  end

  assign o_rd1 = (i_rs1 == 5'd0) ? 64'd0 : registers[i_rs1];
  assign o_rd2 = (i_rs2 == 5'd0) ? 64'd0 : registers[i_rs2];
endmodule

// Top: fetch, decode, control, ALU and next-PC logic around the three storage blocks.
module cpu_sequential_rv64 #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input logic clk,
  input logic reset
);
  localparam int IA_W = $clog2(IMEM_WORDS);
  localparam int DA_W = $clog2(DMEM_WORDS);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_op_t;

  logic [63:0] pc_current;
  logic [31:0] instruction;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        reg_write;
  logic        branch;
  logic        mem_read;
  logic        mem_to_reg;
  logic        mem_write;
  logic        alu_src;
  logic [63:0] alu_result;
  logic [63:0] reg_write_data;
  logic [63:0] reg_read_data1;
  logic [63:0] reg_read_data2;
  logic [63:0] mem_read_data;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic        w_halt;
  alu_op_t     w_alu_op;
  logic [63:0] w_imm;
  logic [63:0] w_alu_b;
  logic [63:0] w_branch_off;
  logic        w_branch_taken;
  logic [63:0] w_pc_next;

  cpu_imem #(.IMEM_WORDS(IMEM_WORDS), .AW(IA_W)) imem (
    .i_addr (pc_current[IA_W+1:2]),
    .o_data (instruction)
  );

  cpu_reg_file reg_file (
    .i_clk  (clk),
    .i_rst  (reset),
    .i_we   (reg_write),
    .i_rs1  (rs1),
    .i_rs2  (rs2),
    .i_rd   (rd),
    .i_wd   (reg_write_data),
    .o_rd1  (reg_read_data1),
    .o_rd2  (reg_read_data2)
  );

  cpu_dmem #(.DMEM_WORDS(DMEM_WORDS), .AW(DA_W)) dmem (
    .i_clk  (clk),
    .i_we   (mem_write),
    .i_addr (alu_result[DA_W+2:3]),
    .i_wd   (reg_read_data2),
    .o_rd   (mem_read_data)
  );

  assign w_opcode = instruction[6:0];
  assign w_funct3 = instruction[14:12];
  assign w_funct7 = instruction[31:25];
  assign rs1      = instruction[19:15];
  assign rs2      = instruction[24:20];
  assign rd       = instruction[11:7];
  assign w_halt   = (instruction == 32'h0);

  // stores use the split S-format immediate, everything else the I-format one
  assign w_imm = (w_opcode == OP_SD)
               ? {{52{instruction[31]}}, instruction[31:25], instruction[11:7]}
               : {{52{instruction[31]}}, instruction[31:20]};

  assign w_branch_off = {{51{instruction[31]}}, instruction[31], instruction[7],
                         instruction[30:25], instruction[11:8], 1'b0};

  // main decoder: an all-zero word halts, unknown opcodes and R-type functs fall through as NOPs
  always_comb begin
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    alu_src   = 1'b0;
    branch    = 1'b0;
    w_alu_op  = ALU_ADD;
    if (!w_halt) begin
      case (w_opcode)
        OP_R: begin
          case (w_funct3)
            3'b000: begin
              if (w_funct7 == 7'b0000000) begin
                reg_write = 1'b1;
                w_alu_op  = ALU_ADD;
              end else if (w_funct7 == 7'b0100000) begin
                reg_write = 1'b1;
                w_alu_op  = ALU_SUB;
              end
            end
            3'b111: begin
              reg_write = 1'b1;
              w_alu_op  = ALU_AND;
            end
            3'b110: begin
              reg_write = 1'b1;
              w_alu_op  = ALU_OR;
            end
            default: reg_write = 1'b0;
          endcase
        end
        OP_ADDI: begin
          reg_write = 1'b1;
          alu_src   = 1'b1;
        end
        OP_LD: begin
          reg_write = 1'b1;
          mem_read  = 1'b1;
          alu_src   = 1'b1;
        end
        OP_SD: begin
          mem_write = 1'b1;
          alu_src   = 1'b1;
        end
        OP_BEQ: begin
          branch   = 1'b1;
          w_alu_op = ALU_SUB;
        end
        default: reg_write = 1'b0;
      endcase
    end
  end

  // loads are the only instructions that write back memory data
  assign mem_to_reg = mem_read;

  assign w_alu_b = alu_src ? w_imm : reg_read_data2;

  // 64-bit ALU, two's-complement wraparound with no overflow detection
  always_comb begin
    case (w_alu_op)
      ALU_ADD: alu_result = reg_read_data1 + w_alu_b;
      ALU_SUB: alu_result = reg_read_data1 - w_alu_b;
      ALU_AND: alu_result = reg_read_data1 & w_alu_b;
      ALU_OR:  alu_result = reg_read_data1 | w_alu_b;
      default: alu_result = reg_read_data1 + w_alu_b;
    endcase
  end

  assign reg_write_data = mem_to_reg ? mem_read_data : alu_result;

  assign w_branch_taken = branch && (alu_result == 64'd0);
  assign w_pc_next      = w_halt         ? pc_current
                        : w_branch_taken ? pc_current + w_branch_off
                        :                  pc_current + 64'd4;

  // program counter: async clear, otherwise advance once per edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_current <= 64'd0;
    end else begin
      pc_current <= w_pc_next;
    end
  end
endmodule

// File: tb/tb_cpu_sequential_rv64.sv
// tb_cpu_sequential_rv64: directed and random programs run on the core and on an
// instruction-level reference model; architectural state is compared every step.
module tb_cpu_sequential_rv64;
  logic clk   = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_rom [0:255];
  logic [63:0] m_mem [0:255] = '{default: 64'h0};
  logic [63:0] m_x   [0:31];
  logic [63:0] m_pc;

  localparam logic [31:0] FACT [0:13] = '{
    32'h00a00513, 32'h00100593, 32'h02050663, 32'h00b00633, 32'h00a006b3,
    32'h00000593, 32'h00068863, 32'h00c585b3, 32'hfff68693, 32'hfe000ae3,
    32'hfff50513, 32'h00050463, 32'hfc000ee3, 32'h00000000};

  cpu_sequential_rv64 #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input int rd, input int rs1, input int rs2);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                        input int rd, input int rs1, input int imm);
    logic [11:0] i12;
    i12 = 12'(imm);
    return {i12, 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] op_add(input int rd, input int a, input int b);
    return enc_r(7'b0000000, 3'b000, rd, a, b);
  endfunction
  function automatic logic [31:0] op_sub(input int rd, input int a, input int b);
    return enc_r(7'b0100000, 3'b000, rd, a, b);
  endfunction
  function automatic logic [31:0] op_and(input int rd, input int a, input int b);
    return enc_r(7'b0000000, 3'b111, rd, a, b);
  endfunction
  function automatic logic [31:0] op_or(input int rd, input int a, input int b);
    return enc_r(7'b0000000, 3'b110, rd, a, b);
  endfunction
  function automatic logic [31:0] op_addi(input int rd, input int a, input int imm);
    return enc_i(7'b0010011, 3'b000, rd, a, imm);
  endfunction
  function automatic logic [31:0] op_ld(input int rd, input int a, input int imm);
    return enc_i(7'b0000011, 3'b011, rd, a, imm);
  endfunction
  function automatic logic [31:0] op_sd(input int src, input int base, input int imm);
    logic [11:0] i12;
    i12 = 12'(imm);
    return {i12[11:5], 5'(src), 5'(base), 3'b011, i12[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] op_beq(input int a, input int b, input int off);
    logic [12:0] o13;
    o13 = 13'(off);
    return {o13[12], o13[10:5], 5'(b), 5'(a), 3'b000, o13[4:1], o13[11], 7'b1100011};
  endfunction

  // ---------------- reference model ----------------
  task automatic m_reset();
    m_pc = 64'd0;
    for (int i = 0; i < 32; i++) m_x[i] = 64'd0;
  endtask

  task automatic m_wr(input logic [4:0] d, input logic [63:0] v);
    if (d != 5'd0) m_x[d] = v;
  endtask

  task automatic m_step();
    logic [31:0] w;
    logic [63:0] a, b, addr, npc;
    longint      imm_i, imm_s, imm_b;
    w     = m_rom[int'((m_pc / 4) % 256)];
    a     = m_x[w[19:15]];
    b     = m_x[w[24:20]];
    imm_i = longint'($signed(w[31:20]));
    imm_s = longint'($signed({w[31:25], w[11:7]}));
    imm_b = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
    npc   = m_pc + 64'd4;
    if (w == 32'h0) begin
      npc = m_pc;
    end else begin
      case (w[6:0])
        7'b0110011: begin
          if (w[14:12] == 3'b000 && w[31:25] == 7'b0000000) m_wr(w[11:7], a + b);
          if (w[14:12] == 3'b000 && w[31:25] == 7'b0100000) m_wr(w[11:7], a - b);
          if (w[14:12] == 3'b111) m_wr(w[11:7], a & b);
          if (w[14:12] == 3'b110) m_wr(w[11:7], a | b);
        end
        7'b0010011: m_wr(w[11:7], a + 64'(imm_i));
        7'b0000011: begin
          addr = a + 64'(imm_i);
          m_wr(w[11:7], m_mem[int'((addr / 8) % 256)]);
        end
        7'b0100011: begin
          addr = a + 64'(imm_s);
          m_mem[int'((addr / 8) % 256)] = b;
        end
        7'b1100011: if (a == b) npc = m_pc + 64'(imm_b);
        default: ;
      endcase
    end
    m_pc = npc;
  endtask

  // ---------------- bench helpers ----------------
  task automatic rom_clear();
    for (int i = 0; i < 256; i++) m_rom[i] = 32'h0;
  endtask

  task automatic start_prog(input string tag);
    reset = 1'b1;
    for (int i = 0; i < 256; i++) dut.imem.memory[i] = m_rom[i];
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({tag, ":rst_pc"}, dut.pc_current, 64'd0);
    for (int i = 0; i < 32; i++)
      chk($sformatf("%s:rst_x%0d", tag, i), dut.reg_file.registers[i], 64'd0);
    reset = 1'b0;
    #1;
  endtask

  task automatic run(input string tag, input int budget, input bit to_halt);
    int          cyc;
    logic [31:0] w;
    logic [6:0]  op;
    bit          halted;
    cyc = 0;
    halted = 1'b0;
    while (cyc < budget) begin
      w      = m_rom[int'((m_pc / 4) % 256)];
      op     = w[6:0];
      halted = (w == 32'h0);
      if (to_halt && halted) break;
      chk({tag, ":instr"}, 64'(dut.instruction), 64'(w));
      chk({tag, ":mem_read"}, 64'(dut.mem_read), 64'(!halted && op == 7'b0000011));
      chk({tag, ":mem_write"}, 64'(dut.mem_write), 64'(!halted && op == 7'b0100011));
      chk({tag, ":reg_write"}, 64'(dut.reg_write),
          64'(!halted && (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011)));
      chk({tag, ":branch"}, 64'(dut.branch), 64'(!halted && op == 7'b1100011));
      m_step();
      @(posedge clk);
      #1;
      chk({tag, ":pc"}, dut.pc_current, m_pc);
      cyc++;
    end
    if (to_halt) begin
      halted = (m_rom[int'((m_pc / 4) % 256)] == 32'h0);
      chk({tag, ":halt_in_budget"}, 64'(halted), 64'd1);
      chk({tag, ":halt_no_regwrite"}, 64'(dut.reg_write), 64'd0);
      chk({tag, ":halt_no_memwrite"}, 64'(dut.mem_write), 64'd0);
      @(posedge clk);
      #1;
      chk({tag, ":halt_pc_hold"}, dut.pc_current, m_pc);
    end
  endtask

  task automatic compare_state(input string tag);
    for (int i = 0; i < 32; i++)
      chk($sformatf("%s:x%0d", tag, i), dut.reg_file.registers[i], m_x[i]);
    for (int i = 0; i < 256; i++)
      chk($sformatf("%s:mem%0d", tag, i), dut.dmem.memory[i], m_mem[i]);
  endtask

  task automatic gen_random(input int n);
    int          idx, sel, rd, a, b, k, imm, lim;
    logic [31:0] rw;
    rom_clear();
    idx = 0;
    for (int r = 1; r < 8; r++) begin
      m_rom[idx] = op_addi(r, 0, int'($urandom_range(0, 4095)));
      idx++;
    end
    lim = 7 + n;
    for (int j = 0; j < n; j++) begin
      sel = int'($urandom_range(0, 9));
      rd  = int'($urandom_range(0, 7));
      a   = int'($urandom_range(0, 7));
      b   = int'($urandom_range(0, 7));
      imm = int'($urandom_range(0, 4095));
      case (sel)
        0: m_rom[idx] = op_add(rd, a, b);
        1: m_rom[idx] = op_sub(rd, a, b);
        2: m_rom[idx] = op_and(rd, a, b);
        3: m_rom[idx] = op_or(rd, a, b);
        4: m_rom[idx] = op_addi(rd, a, imm);
        5, 6: m_rom[idx] = op_ld(rd, a, imm);
        7: m_rom[idx] = op_sd(b, a, imm);
        8: begin
          if ($urandom_range(0, 2) == 0) b = a;
          k = int'($urandom_range(1, 3));
          if (idx + k > lim) k = lim - idx;
          m_rom[idx] = op_beq(a, b, 4 * k);
        end
        default: begin
          rw = $urandom();
          m_rom[idx] = {rw[31:7], 7'b1111111};
        end
      endcase
      idx++;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    // factorial of 10
    rom_clear();
    for (int i = 0; i < 14; i++) m_rom[i] = FACT[i];
    start_prog("fact");
    run("fact", 5000, 1'b1);
    chk("fact:final_pc", dut.pc_current, 64'h34);
    chk("fact:x10", dut.reg_file.registers[10], 64'd0);
    chk("fact:x11", dut.reg_file.registers[11], 64'd3628800);
    chk("fact:x12", dut.reg_file.registers[12], 64'd3628800);
    chk("fact:x13", dut.reg_file.registers[13], 64'd0);
    compare_state("fact");

    // store then load through memory word 2
    rom_clear();
    m_rom[0] = op_addi(5, 0, 7);
    m_rom[1] = op_sd(5, 0, 16);
    m_rom[2] = op_ld(6, 0, 16);
    start_prog("ldsd");
    run("ldsd", 50, 1'b1);
    chk("ldsd:mem2", dut.dmem.memory[2], 64'd7);
    chk("ldsd:x6", dut.reg_file.registers[6], 64'd7);
    compare_state("ldsd");

    // ALU operations, negative immediate, rd==rs1
    rom_clear();
    m_rom[0] = op_addi(1, 0, 5);
    m_rom[1] = op_addi(2, 0, 3);
    m_rom[2] = op_sub(3, 1, 2);
    m_rom[3] = op_and(4, 1, 2);
    m_rom[4] = op_or(5, 1, 2);
    m_rom[5] = op_addi(7, 0, -1);
    m_rom[6] = op_add(6, 1, 2);
    m_rom[7] = op_add(1, 1, 2);
    start_prog("alu");
    run("alu", 50, 1'b1);
    chk("alu:sub", dut.reg_file.registers[3], 64'd2);
    chk("alu:and", dut.reg_file.registers[4], 64'd1);
    chk("alu:or", dut.reg_file.registers[5], 64'd7);
    chk("alu:addi_neg", dut.reg_file.registers[7], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("alu:add", dut.reg_file.registers[6], 64'd8);
    chk("alu:rd_eq_rs1", dut.reg_file.registers[1], 64'd8);
    compare_state("alu");

    // x0 write ignored, branch not taken / forward / backward, NOP opcode
    rom_clear();
    m_rom[0]  = op_addi(1, 0, 5);
    m_rom[1]  = op_addi(2, 0, 3);
    m_rom[2]  = op_addi(8, 0, 2);
    m_rom[3]  = op_addi(0, 0, 5);
    m_rom[4]  = op_beq(1, 2, 8);
    m_rom[5]  = 32'h0000007f;
    m_rom[6]  = op_addi(6, 6, 1);
    m_rom[7]  = op_beq(6, 8, 12);
    m_rom[8]  = op_beq(0, 0, -8);
    m_rom[9]  = op_addi(9, 0, 1);
    start_prog("br");
    run("br", 50, 1'b1);
    chk("br:x0", dut.reg_file.registers[0], 64'd0);
    chk("br:x6", dut.reg_file.registers[6], 64'd2);
    chk("br:x9_skipped", dut.reg_file.registers[9], 64'd0);
    chk("br:final_pc", dut.pc_current, 64'h28);
    compare_state("br");

    // asynchronous reset in the middle of the factorial loop, then rerun
    rom_clear();
    for (int i = 0; i < 14; i++) m_rom[i] = FACT[i];
    start_prog("mid");
    run("mid", 60, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    chk("mid:async_pc", dut.pc_current, 64'd0);
    for (int i = 0; i < 32; i++)
      chk($sformatf("mid:async_x%0d", i), dut.reg_file.registers[i], 64'd0);
    m_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    run("mid_rerun", 5000, 1'b1);
    chk("mid:final_pc", dut.pc_current, 64'h34);
    chk("mid:x11", dut.reg_file.registers[11], 64'd3628800);
    chk("mid:x12", dut.reg_file.registers[12], 64'd3628800);
    compare_state("mid");

    // random programs against the model; data memory carries over between programs
    for (int p = 0; p < 8; p++) begin
      gen_random(40);
      start_prog($sformatf("rnd%0d", p));
      run($sformatf("rnd%0d", p), 200, 1'b1);
      compare_state($sformatf("rnd%0d", p));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
